// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: control stage that feeds one PE neuron.
// On i_start it walks N_OUT neurons. For each neuron it clears the PE accumulator and streams
// N_IN input/weight pairs from two sync-read memories. It then waits out the activation latency
// and offers the 8-bit PE result downstream on a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst             clock (rising edge), asynchronous active-low reset
//   i_start                  start a run (sampled only while idle)
//   i_op_activation          0 ReLu, 1 Sigmoid (latched at start)
//   i_no_rect                bypass activation/quantize (latched at start)
//   o_x_addr / i_x_data      input-memory address / data (data returns one cycle later)
//   o_w_addr / i_w_data      weight-memory address (neuron*N_IN + k) / data
//   o_pe_data, o_pe_weight   PE operands, zero outside MAC
//   o_pe_acc_clr             PE accumulator clear
//   o_pe_op_act, o_pe_no_rect latched mode pins to the PE
//   i_pe_data, i_pe_decision PE result and decision bit
//   o_valid / i_ready        downstream result handshake
//   o_result, o_decision     captured PE outputs
//   o_neuron                 neuron index for o_result
//   o_busy                   high whenever the sequencer is not idle
module pe_mac_sequencer #(
  parameter int unsigned N_IN    = 16,
  parameter int unsigned N_OUT   = 4,
  parameter int unsigned X_AW    = 4,
  parameter int unsigned W_AW    = 6,
  parameter int unsigned SIG_LAT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_op_activation,
  input  logic                       i_no_rect,
  output logic [X_AW-1:0]            o_x_addr,
  input  logic [7:0]                 i_x_data,
  output logic [W_AW-1:0]            o_w_addr,
  input  logic [7:0]                 i_w_data,
  output logic [7:0]                 o_pe_data,
  output logic [7:0]                 o_pe_weight,
  output logic                       o_pe_acc_clr,
  output logic                       o_pe_op_act,
  output logic                       o_pe_no_rect,
  input  logic [7:0]                 i_pe_data,
  input  logic                       i_pe_decision,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [7:0]                 o_result,
  output logic                       o_decision,
  output logic [$clog2(N_OUT):0]     o_neuron,
  output logic                       o_busy
);

  localparam int unsigned NW = $clog2(N_OUT) + 1;
  localparam int unsigned KW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned CW = $clog2(SIG_LAT + 2);

  typedef enum logic [2:0] {StIdle, StClr, StMac, StWait, StResult} state_e;

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   wait_q;
  logic [NW-1:0]   neuron_q;
  logic [CW-1:0]   wait_len;
  logic            last_k;
  logic            more_addr;

  // Sigmoid needs its pipeline to drain; ReLu and bypass results are ready one cycle after MAC.
  assign wait_len  = (!o_pe_op_act || o_pe_no_rect) ? CW'(1) : CW'(SIG_LAT + 1);
  assign last_k    = (k_q == KW'(N_IN - 1));
  // Address for element k+2 is still needed while k+2 <= N_IN-1.
  assign more_addr = ((32'(k_q) + 32'd2) < N_IN);

  // Operands are only live in MAC so the PE accumulator holds everywhere else.
  assign o_pe_data   = (state_q == StMac) ? i_x_data : 8'h00;
  assign o_pe_weight = (state_q == StMac) ? i_w_data : 8'h00;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      wait_q       <= '0;
      neuron_q     <= '0;
      o_x_addr     <= '0;
      o_w_addr     <= '0;
      o_pe_acc_clr <= 1'b0;
      o_pe_op_act  <= 1'b0;
      o_pe_no_rect <= 1'b0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_decision   <= 1'b0;
      o_neuron     <= '0;
      o_busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            o_pe_op_act  <= i_op_activation;
            o_pe_no_rect <= i_no_rect;
            neuron_q     <= '0;
            k_q          <= '0;
            o_x_addr     <= '0;
            o_w_addr     <= '0;
            o_pe_acc_clr <= 1'b1;
            o_busy       <= 1'b1;
            state_q      <= StClr;
          end
        end
        StClr: begin
          o_pe_acc_clr <= 1'b0;
          k_q          <= '0;
          state_q      <= StMac;
          // Element 0 is already addressed; present element 1 during MAC k=0.
          if (N_IN > 1) begin
            o_x_addr <= o_x_addr + X_AW'(1);
            o_w_addr <= o_w_addr + W_AW'(1);
          end
        end
        StMac: begin
          if (last_k) begin
            wait_q  <= '0;
            state_q <= StWait;
          end else begin
            k_q <= k_q + KW'(1);
            if (more_addr) begin
              o_x_addr <= o_x_addr + X_AW'(1);
              o_w_addr <= o_w_addr + W_AW'(1);
            end
          end
        end
        StWait: begin
          if (wait_q == wait_len - CW'(1)) begin
            o_result   <= i_pe_data;
            o_decision <= i_pe_decision;
            o_neuron   <= neuron_q;
            o_valid    <= 1'b1;
            state_q    <= StResult;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        StResult: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (neuron_q == NW'(N_OUT - 1)) begin
              o_busy  <= 1'b0;
              state_q <= StIdle;
            end else begin
              neuron_q     <= neuron_q + NW'(1);
              o_x_addr     <= '0;
              // Weight address already points at the previous neuron's last element.
              o_w_addr     <= o_w_addr + W_AW'(1);
              o_pe_acc_clr <= 1'b1;
              state_q      <= StClr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Bench for pe_mac_sequencer with a behavioural PE and sync-read memories.
// Stimulus pushes expected results and weight addresses; a negedge monitor pops and compares.
module tb_pe_mac_sequencer;
  localparam int N_IN    = 4;
  localparam int N_OUT   = 2;
  localparam int X_AW    = 4;
  localparam int W_AW    = 6;
  localparam int SIG_LAT = 4;
  localparam int NW      = $clog2(N_OUT) + 1;

  logic            clk, rst, start, op_act, no_rect, ready;
  logic [X_AW-1:0] x_addr;
  logic [W_AW-1:0] w_addr;
  logic [7:0]      x_data, w_data, pe_data, pe_weight, pe_res, result;
  logic            pe_acc_clr, pe_op_act, pe_no_rect, pe_dec, valid, decision, busy;
  logic [NW-1:0]   neuron;

  pe_mac_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .X_AW(X_AW), .W_AW(W_AW), .SIG_LAT(SIG_LAT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_activation(op_act), .i_no_rect(no_rect),
    .o_x_addr(x_addr), .i_x_data(x_data), .o_w_addr(w_addr), .i_w_data(w_data),
    .o_pe_data(pe_data), .o_pe_weight(pe_weight), .o_pe_acc_clr(pe_acc_clr),
    .o_pe_op_act(pe_op_act), .o_pe_no_rect(pe_no_rect), .i_pe_data(pe_res),
    .i_pe_decision(pe_dec), .o_valid(valid), .i_ready(ready), .o_result(result),
    .o_decision(decision), .o_neuron(neuron), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read memories.
  logic [7:0] xmem [16];
  logic [7:0] wmem [64];
  always @(posedge clk) begin
    x_data <= xmem[x_addr];
    w_data <= wmem[w_addr];
  end

  // Behavioural PE (Qw=1): accumulator, SIG_LAT-deep sigmoid pipeline, mock sigmoid 64+clamp(acc).
  logic signed [31:0] acc;
  logic signed [31:0] pipe [SIG_LAT];
  logic signed [31:0] sig_in;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 0;
      for (int i = 0; i < SIG_LAT; i++) pipe[i] <= 0;
    end else begin
      if (pe_acc_clr) acc <= 0;
      else acc <= acc + $signed(pe_data) * $signed(pe_weight);
      pipe[0] <= acc;
      for (int i = 1; i < SIG_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  always_comb begin
    pe_res = 8'h00;
    pe_dec = 1'b0;
    sig_in = pipe[SIG_LAT-1];
    if (pe_no_rect) begin
      pe_res = acc[7:0];
      pe_dec = (acc > 0);
    end else if (!pe_op_act) begin
      pe_dec = (acc > 0);
      if (acc < 0) pe_res = 8'h00;
      else if (acc > 127) pe_res = 8'd127;
      else pe_res = acc[7:0];
    end else begin
      pe_dec = (sig_in > 0);
      if (sig_in < -64) pe_res = 8'h00;
      else if (sig_in > 63) pe_res = 8'd127;
      else pe_res = 8'(sig_in + 64);
    end
  end

  typedef struct {
    logic [7:0]    res;
    logic          dec;
    logic [NW-1:0] nrn;
    int            lat;
  } exp_t;

  exp_t            exp_q[$];
  logic [W_AW-1:0] addr_q[$];
  int total = 0;
  int bad   = 0;
  int xfers = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] r, input logic d, input int n, input int l);
    exp_t e;
    e.res = r;
    e.dec = d;
    e.nrn = NW'(n);
    e.lat = l;
    exp_q.push_back(e);
  endtask

  task automatic push_addrs();
    for (int i = 0; i < N_IN * N_OUT; i++) addr_q.push_back(W_AW'(i));
  endtask

  // Monitor: sampled at negedge, away from the active edge.
  int              ncnt   = 0;
  int              ref_n  = 0;
  int              cap    = 0;
  logic            prev_v = 1'b0;
  exp_t            em;
  logic [W_AW-1:0] am;
  always @(negedge clk) begin
    ncnt++;
    if (!rst) begin
      cap    = 0;
      prev_v = 1'b0;
    end else begin
      if (pe_acc_clr) cap = N_IN;
      if (cap > 0) begin
        if (addr_q.size() == 0) check(1'b0, "w_addr_unexpected", w_addr, -1);
        else begin
          am = addr_q.pop_front();
          check(w_addr == am, "w_addr", w_addr, am);
        end
        cap--;
      end
      if (valid) begin
        if (exp_q.size() == 0) check(1'b0, "valid_unexpected", result, -1);
        else begin
          em = exp_q[0];
          if (!prev_v) check(ncnt - ref_n - 1 == em.lat, "latency", ncnt - ref_n - 1, em.lat);
          check(result == em.res, "result", result, em.res);
          check(decision == em.dec, "decision", decision, em.dec);
          check(neuron == em.nrn, "neuron", neuron, em.nrn);
          check(pe_data == 8'h00 && pe_weight == 8'h00, "operands_idle", pe_data, 0);
          check(pe_acc_clr == 1'b0, "no_clr_in_result", pe_acc_clr, 0);
          if (ready) begin
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end
      if (valid && ready) ref_n = ncnt;
      if (start && !busy) ref_n = ncnt;
      prev_v = valid;
    end
  end

  task automatic check_zero(input string tag);
    check(valid == 0 && busy == 0 && pe_acc_clr == 0, {tag, "_ctrl"},
          {valid, busy, pe_acc_clr}, 0);
    check(result == 0 && decision == 0 && neuron == 0, {tag, "_result"}, result, 0);
    check(x_addr == 0 && w_addr == 0, {tag, "_addr"}, w_addr, 0);
    check(pe_op_act == 0 && pe_no_rect == 0, {tag, "_modes"}, {pe_op_act, pe_no_rect}, 0);
    check(pe_data == 0 && pe_weight == 0, {tag, "_operands"}, pe_weight, 0);
  endtask

  task automatic start_run(input logic op, input logic nr);
    @(posedge clk); #1;
    op_act  = op;
    no_rect = nr;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check(!busy, {tag, "_idle"}, busy, 0);
    check(exp_q.size() == 0, {tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (valid) break;
      @(posedge clk); #1;
    end
    check(valid, {tag, "_valid_seen"}, valid, 1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) xmem[i] = 8'h00;
    for (int i = 0; i < 64; i++) wmem[i] = 8'h00;
    for (int i = 0; i < N_IN; i++) begin
      xmem[i]        = 8'(i + 1);
      wmem[i]        = 8'h01;
      wmem[N_IN + i] = 8'hFF;
    end
  endtask

  int x0;

  initial begin
    rst = 1'b1; start = 1'b0; op_act = 1'b0; no_rect = 1'b0; ready = 1'b1;
    load_basic();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    // ReLu: acc 10 and -10.
    push_exp(8'd10, 1'b1, 0, 6);
    push_exp(8'd0, 1'b0, 1, 6);
    push_addrs();
    start_run(1'b0, 1'b0);
    wait_idle("relu");

    // Sigmoid; mode inputs flipped mid-run must not matter.
    push_exp(8'd74, 1'b1, 0, 10);
    push_exp(8'd54, 1'b0, 1, 10);
    push_addrs();
    start_run(1'b1, 1'b0);
    op_act = 1'b0; no_rect = 1'b1;
    wait_idle("sigmoid");

    // Bypass: 4*127*127 = 64516 -> low byte 0x04.
    for (int i = 0; i < N_IN; i++) xmem[i] = 8'd127;
    for (int i = 0; i < N_IN * N_OUT; i++) wmem[i] = 8'd127;
    push_exp(8'h04, 1'b1, 0, 6);
    push_exp(8'h04, 1'b1, 1, 6);
    push_addrs();
    start_run(1'b1, 1'b1);
    wait_idle("norect");

    // Backpressure: ready held low for 7 cycles in RESULT.
    load_basic();
    ready = 1'b0;
    push_exp(8'd10, 1'b1, 0, 6);
    push_exp(8'd0, 1'b0, 1, 6);
    push_addrs();
    start_run(1'b0, 1'b0);
    wait_valid("stall0");
    repeat (7) begin @(posedge clk); #1; end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    wait_valid("stall1");
    ready = 1'b1;
    wait_idle("stall");

    // Reset during MAC of neuron 1, then a clean run.
    push_exp(8'd10, 1'b1, 0, 6);
    push_addrs();
    start_run(1'b0, 1'b0);
    wait_valid("rstrun");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1 check_zero("midrun_reset");
    @(posedge clk); #1 rst = 1'b1;
    push_exp(8'd10, 1'b1, 0, 6);
    push_exp(8'd0, 1'b0, 1, 6);
    push_addrs();
    start_run(1'b0, 1'b0);
    wait_idle("after_reset");

    // Start pulsed while busy is ignored.
    x0 = xfers;
    push_exp(8'd10, 1'b1, 0, 6);
    push_exp(8'd0, 1'b0, 1, 6);
    push_addrs();
    start_run(1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("busy_start");
    repeat (20) begin @(posedge clk); #1; end
    check(xfers - x0 == N_OUT, "transfer_count", xfers - x0, N_OUT);
    check(!busy && !valid, "quiet_after_run", {busy, valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
